// File: rtl/pipeline_pkg.sv
// Shared stage-register layout and write-enable rule for the MEM/WB back end.
package pipeline_pkg;

    localparam int unsigned RD_W     = 5;
    localparam int unsigned STAGE_VW = 256;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                wb_sel;
        logic                vec;
        logic [RD_W-1:0]     rd;
        logic [STAGE_VW-1:0] result;
    } stage_t;

    // Scalar x0 is hard-wired zero; vector v0 is an ordinary register.
    function automatic logic eff_we(input stage_t s);
        return s.valid & s.we & ~(~s.vec & (s.rd == '0));
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register; load_bubble replaces the incoming instruction with all-zero.
module pipe_stage_reg
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_bubble,
    input  stage_t next_stage,
    output stage_t stage
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (load_bubble) begin
            stage <= '0;
        end else begin
            stage <= next_stage;
        end
    end

endmodule

// File: rtl/writeback_pipe.sv
// MEM/WB back end: stage registers, load-data mux, register-file strobes and perf counters.
module writeback_pipe
    import pipeline_pkg::*;
#(
    parameter int unsigned VW = 256,
    parameter int unsigned CW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_ex,
    input  logic            we_ex,
    input  logic            wb_sel_ex,
    input  logic            vec_ex,
    input  logic [4:0]      rd_ex,
    input  logic [VW-1:0]   result_ex,
    input  logic            flush,
    input  logic            stall,
    input  logic [VW-1:0]   mem_rdata,
    output logic            ex_ready,
    output logic            mem_re,
    output logic [31:0]     mem_addr,
    output logic            wb_sel,
    output logic            write_enable_mem,
    output logic            write_enable_wb,
    output logic [4:0]      rd_mem,
    output logic [4:0]      rd_wb,
    output logic [VW-1:0]   result_mem,
    output logic [VW-1:0]   result_wb,
    output logic            rf_we_s,
    output logic            rf_we_v,
    output logic [4:0]      rf_waddr,
    output logic [VW-1:0]   rf_wdata,
    output logic [CW-1:0]   retired,
    output logic [CW-1:0]   stall_cycles
);

    stage_t        ex_stage;
    stage_t        mem_stage;
    stage_t        wb_stage;
    logic          accept;
    logic [CW-1:0] retired_q;
    logic [CW-1:0] stall_q;

    always_comb begin
        ex_stage        = '0;
        ex_stage.valid  = valid_ex;
        ex_stage.we     = we_ex;
        ex_stage.wb_sel = wb_sel_ex;
        ex_stage.vec    = vec_ex;
        ex_stage.rd     = rd_ex;
        ex_stage.result = STAGE_VW'(result_ex);
    end

    // flush dominates stall; either way the EX instruction is not captured
    assign accept = valid_ex & ~stall & ~flush;

    pipe_stage_reg u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_bubble(~accept),
        .next_stage (ex_stage),
        .stage      (mem_stage)
    );

    pipe_stage_reg u_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_bubble(1'b0),
        .next_stage (mem_stage),
        .stage      (wb_stage)
    );

    assign ex_ready         = ~stall;
    assign mem_re           = mem_stage.valid & mem_stage.we & ~mem_stage.wb_sel;
    assign mem_addr         = mem_stage.result[31:0];
    assign wb_sel           = mem_stage.wb_sel;
    assign write_enable_mem = eff_we(mem_stage);
    assign write_enable_wb  = eff_we(wb_stage);
    assign rd_mem           = mem_stage.rd;
    assign rd_wb            = wb_stage.rd;
    assign result_mem       = mem_stage.result[VW-1:0];
    // load data arrives in the WB cycle and is muxed in combinationally so it can be forwarded
    assign result_wb        = wb_stage.wb_sel ? wb_stage.result[VW-1:0] : mem_rdata;

    assign rf_we_s  = write_enable_wb & ~wb_stage.vec;
    assign rf_we_v  = write_enable_wb & wb_stage.vec;
    assign rf_waddr = wb_stage.rd;
    assign rf_wdata = result_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (wb_stage.valid) begin
                retired_q <= retired_q + CW'(1);
            end
            if (stall) begin
                stall_q <= stall_q + CW'(1);
            end
        end
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_writeback_pipe.sv
// Randomised and directed bench for writeback_pipe against an instruction-history model.
module tb_writeback_pipe;

    localparam int unsigned VW = 256;
    localparam int unsigned CW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_ex = 1'b0, we_ex = 1'b0, wb_sel_ex = 1'b0, vec_ex = 1'b0;
    logic [4:0]      rd_ex = '0;
    logic [VW-1:0]   result_ex = '0;
    logic            flush = 1'b0, stall = 1'b0;
    logic [VW-1:0]   mem_rdata = '0;
    logic            ex_ready, mem_re, wb_sel, write_enable_mem, write_enable_wb;
    logic [31:0]     mem_addr;
    logic [4:0]      rd_mem, rd_wb, rf_waddr;
    logic [VW-1:0]   result_mem, result_wb, rf_wdata;
    logic            rf_we_s, rf_we_v;
    logic [CW-1:0]   retired, stall_cycles;

    writeback_pipe #(.VW(VW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .we_ex(we_ex),
        .wb_sel_ex(wb_sel_ex), .vec_ex(vec_ex), .rd_ex(rd_ex), .result_ex(result_ex),
        .flush(flush), .stall(stall), .mem_rdata(mem_rdata), .ex_ready(ex_ready),
        .mem_re(mem_re), .mem_addr(mem_addr), .wb_sel(wb_sel),
        .write_enable_mem(write_enable_mem), .write_enable_wb(write_enable_wb),
        .rd_mem(rd_mem), .rd_wb(rd_wb), .result_mem(result_mem), .result_wb(result_wb),
        .rf_we_s(rf_we_s), .rf_we_v(rf_we_v), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retired(retired), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           valid;
        bit           we;
        bit           wbsel;
        bit           vec;
        bit [4:0]     rd;
        logic [VW-1:0] res;
    } ins_t;

    // model: what was accepted one edge ago sits in MEM, two edges ago in WB
    ins_t          m_mem, m_wb, bubble;
    logic [CW-1:0] m_retired, m_stalls;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit writes(input ins_t i);
        return i.valid && i.we && (i.vec || i.rd != 0);
    endfunction

    task automatic compare_model();
        logic [VW-1:0] exp_wb;
        exp_wb = m_wb.wbsel ? m_wb.res : mem_rdata;
        chk("ex_ready", VW'(ex_ready), VW'(!stall));
        chk("mem_re", VW'(mem_re), VW'(m_mem.valid && m_mem.we && !m_mem.wbsel));
        chk("mem_addr", VW'(mem_addr), VW'(m_mem.res[31:0]));
        chk("wb_sel", VW'(wb_sel), VW'(m_mem.wbsel));
        chk("write_enable_mem", VW'(write_enable_mem), VW'(writes(m_mem)));
        chk("write_enable_wb", VW'(write_enable_wb), VW'(writes(m_wb)));
        chk("rd_mem", VW'(rd_mem), VW'(m_mem.rd));
        chk("rd_wb", VW'(rd_wb), VW'(m_wb.rd));
        chk("result_mem", result_mem, m_mem.res);
        chk("result_wb", result_wb, exp_wb);
        chk("rf_we_s", VW'(rf_we_s), VW'(writes(m_wb) && !m_wb.vec));
        chk("rf_we_v", VW'(rf_we_v), VW'(writes(m_wb) && m_wb.vec));
        chk("rf_waddr", VW'(rf_waddr), VW'(m_wb.rd));
        chk("rf_wdata", rf_wdata, exp_wb);
        chk("retired", VW'(retired), VW'(m_retired));
        chk("stall_cycles", VW'(stall_cycles), VW'(m_stalls));
    endtask

    // called at a negedge: drive EX inputs, take the edge, then present WB-cycle read data
    task automatic cycle(input bit v, input bit we, input bit ws, input bit vec,
                         input bit [4:0] rd, input logic [VW-1:0] res,
                         input bit fl, input bit st, input logic [VW-1:0] rdata);
        ins_t n;
        valid_ex = v; we_ex = we; wb_sel_ex = ws; vec_ex = vec;
        rd_ex = rd; result_ex = res; flush = fl; stall = st;
        @(posedge clk);
        if (rst_n) begin
            if (m_wb.valid) m_retired = m_retired + 1'b1;
            if (st) m_stalls = m_stalls + 1'b1;
            m_wb = m_mem;
            n.valid = 1'b1; n.we = we; n.wbsel = ws; n.vec = vec; n.rd = rd; n.res = res;
            m_mem = (v && !st && !fl) ? n : bubble;
        end
        #1 mem_rdata = rdata;
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 5'd0, '0, 0, 0, '0);
    endtask

    task automatic model_clear();
        m_mem = bubble; m_wb = bubble; m_retired = '0; m_stalls = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        cycle(1, 1, 1, 0, 5'd5, 256'h77, 0, 0, '0);
        cycle(1, 1, 1, 0, 5'd5, 256'h77, 0, 0, '0);
        rst_n = 1'b1;
    endtask

    function automatic logic [VW-1:0] rand_wide();
        logic [VW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] ones;
        ones = '1;
        bubble = '{valid: 0, we: 0, wbsel: 0, vec: 0, rd: 0, res: '0};
        model_clear();
        @(negedge clk);

        // reset with a valid instruction presented
        do_reset();
        chk("rst write_enable_mem", VW'(write_enable_mem), '0);
        chk("rst write_enable_wb", VW'(write_enable_wb), '0);
        chk("rst retired", VW'(retired), '0);
        cycle(1, 1, 1, 0, 5'd5, 256'h21, 0, 0, '0);
        idle();
        chk("first rd_wb", VW'(rd_wb), VW'(5));

        // ALU chain
        cycle(1, 1, 1, 0, 5'd3, 256'h5, 0, 0, '0);
        chk("alu rd_mem", VW'(rd_mem), VW'(3));
        chk("alu result_mem", result_mem, 256'h5);
        cycle(1, 1, 1, 0, 5'd4, 256'h9, 0, 0, '0);
        chk("alu rd_wb", VW'(rd_wb), VW'(3));
        chk("alu rf_we_s", VW'(rf_we_s), VW'(1));
        chk("alu rf_wdata", VW'(rf_wdata[31:0]), VW'(32'h5));
        idle(); idle();

        // load-use from a clean reset so counters are known
        do_reset();
        cycle(1, 1, 0, 0, 5'd7, 256'h40, 0, 0, '0);
        chk("lu mem_re", VW'(mem_re), VW'(1));
        cycle(1, 1, 1, 0, 5'd8, 256'h11, 0, 1, 256'hABCD);
        chk("lu bubble we", VW'(write_enable_mem), '0);
        chk("lu bubble rd", VW'(rd_mem), '0);
        chk("lu result_wb", result_wb, 256'hABCD);
        chk("lu stall_cycles", VW'(stall_cycles), VW'(1));
        chk("lu retired0", VW'(retired), '0);
        cycle(1, 1, 1, 0, 5'd8, 256'h11, 0, 0, '0);
        chk("lu dep rd_mem", VW'(rd_mem), VW'(8));
        chk("lu retired1", VW'(retired), VW'(1));
        idle();
        chk("lu retired1b", VW'(retired), VW'(1));
        idle();
        chk("lu retired2", VW'(retired), VW'(2));

        // scalar x0 is dropped, vector v0 is written
        cycle(1, 1, 1, 0, 5'd0, 256'h7, 0, 0, '0);
        chk("x0 write_enable_mem", VW'(write_enable_mem), '0);
        cycle(1, 1, 1, 1, 5'd0, ones, 0, 0, '0);
        chk("x0 rf_we_s", VW'(rf_we_s), '0);
        idle();
        chk("v0 rf_we_v", VW'(rf_we_v), VW'(1));
        chk("v0 rf_wdata", rf_wdata, ones);

        // flush together with stall
        cycle(1, 1, 1, 0, 5'd9, 256'h99, 1, 1, '0);
        chk("fs rd_mem", VW'(rd_mem), '0);
        chk("fs write_enable_mem", VW'(write_enable_mem), '0);
        idle();
        chk("fs rd_wb", VW'(rd_wb), '0);
        chk("fs write_enable_wb", VW'(write_enable_wb), '0);

        // retire counter wrap
        cycle(1, 1, 1, 0, 5'd2, 256'h3, 0, 0, '0);
        idle();
        force dut.retired_q = '1;
        #1 release dut.retired_q;
        m_retired = '1;
        idle();
        chk("wrap retired", VW'(retired), '0);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                  rand_wide(), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  rand_wide());
        end

        // asynchronous reset with the pipeline full
        cycle(1, 1, 1, 0, 5'd11, 256'h1, 0, 0, '0);
        cycle(1, 1, 1, 1, 5'd12, 256'h2, 0, 0, '0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async rf_we_s", VW'(rf_we_s), '0);
        chk("async rf_we_v", VW'(rf_we_v), '0);
        chk("async write_enable_mem", VW'(write_enable_mem), '0);
        chk("async retired", VW'(retired), '0);
        model_clear();
        mem_rdata = '0;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
